// File: rtl/apb_cmd_sequencer_if.sv
// Host command/response ports and the mul_slave command/return bus of the sequencer.
// The slave modport is the sequencer's view; master is the host plus subsystem side.
interface apb_cmd_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_slv;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_wr;

    logic [1:0] slv_addr_o;
    logic [3:0] addr_o;
    logic [7:0] data_o;
    logic       wr_o;
    logic       newd_o;
    logic [7:0] dataout_i;
    logic       slverr_i;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       rsp_wr;
    logic       busy;

    modport slave (
        input  cmd_valid, cmd_slv, cmd_addr, cmd_data, cmd_wr,
        input  dataout_i, slverr_i, rsp_ready,
        output cmd_ready, slv_addr_o, addr_o, data_o, wr_o, newd_o,
        output rsp_valid, rsp_data, rsp_err, rsp_wr, busy
    );

    modport master (
        output cmd_valid, cmd_slv, cmd_addr, cmd_data, cmd_wr,
        output dataout_i, slverr_i, rsp_ready,
        input  cmd_ready, slv_addr_o, addr_o, data_o, wr_o, newd_o,
        input  rsp_valid, rsp_data, rsp_err, rsp_wr, busy
    );
endinterface

// File: rtl/apb_cmd_sequencer.sv
// Buffers host commands in a FIFO and replays them one at a time onto the mul_slave
// newd/wr/addr/data interface with fixed hold and settle timing, returning one response each.
module apb_cmd_sequencer #(
    parameter int DEPTH        = 4,
    parameter int ISSUE_CYCLES = 2,
    parameter int WAIT_CYCLES  = 3
) (
    input  logic                 pclk,
    input  logic                 presetn,
    apb_cmd_sequencer_if.slave   bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CMAX = (ISSUE_CYCLES > WAIT_CYCLES) ? ISSUE_CYCLES : WAIT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // FIFO entry layout: {slv[1:0], addr[3:0], data[7:0], wr}
    logic [14:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [14:0]   w_head;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_newd;
    logic          w_newd_nxt;
    logic          w_load;

    logic [1:0]    r_slv;
    logic [3:0]    r_addr;
    logic [7:0]    r_data;
    logic          r_wr;

    logic          r_rsp_valid;
    logic          w_rsp_valid_nxt;
    logic [7:0]    r_rsp_data;
    logic [7:0]    w_rsp_data_nxt;
    logic          r_rsp_err;
    logic          w_rsp_err_nxt;
    logic          r_rsp_wr;
    logic          w_rsp_wr_nxt;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.cmd_valid && !w_full;
    assign w_head  = r_mem[r_rptr];

    // Storage carries data only; occupancy is tracked by the reset pointers/count.
    always_ff @(posedge pclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {bus.cmd_slv, bus.cmd_addr, bus.cmd_data, bus.cmd_wr};
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_newd      <= 1'b0;
            r_slv       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wr        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_wr    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_newd      <= w_newd_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
            r_rsp_wr    <= w_rsp_wr_nxt;
            if (w_load) begin
                r_slv  <= w_head[14:13];
                r_addr <= w_head[12:9];
                r_data <= w_head[8:1];
                r_wr   <= w_head[0];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_newd_nxt      = r_newd;
        w_pop           = 1'b0;
        w_load          = 1'b0;
        w_rsp_valid_nxt = r_rsp_valid;
        w_rsp_data_nxt  = r_rsp_data;
        w_rsp_err_nxt   = r_rsp_err;
        w_rsp_wr_nxt    = r_rsp_wr;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop  = 1'b1;
                    w_load = 1'b1;
                    // Selects 00/11 address no slave: answer locally, never touch newd.
                    if (w_head[14:13] == 2'b00 || w_head[14:13] == 2'b11) begin
                        w_rsp_valid_nxt = 1'b1;
                        w_rsp_err_nxt   = 1'b1;
                        w_rsp_data_nxt  = '0;
                        w_rsp_wr_nxt    = w_head[0];
                        w_state_nxt     = S_RESP;
                    end else begin
                        w_newd_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (r_cnt == CW'(ISSUE_CYCLES - 1)) begin
                    w_newd_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_WAIT;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_WAIT: begin
                if (r_cnt == CW'(WAIT_CYCLES - 1)) begin
                    w_rsp_valid_nxt = 1'b1;
                    w_rsp_err_nxt   = bus.slverr_i;
                    w_rsp_data_nxt  = r_wr ? 8'h00 : bus.dataout_i;
                    w_rsp_wr_nxt    = r_wr;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.cmd_ready  = !w_full;
    assign bus.slv_addr_o = r_slv;
    assign bus.addr_o     = r_addr;
    assign bus.data_o     = r_data;
    assign bus.wr_o       = r_wr;
    assign bus.newd_o     = r_newd;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.rsp_wr     = r_rsp_wr;
    assign bus.busy       = (r_state != S_IDLE) || !w_empty;
endmodule
